// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage encodings: load size, write-data source and FSM state.
package cpu_consts;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2,
        DOUBLE    = 2'd3
    } byte_en_t;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MEM = 2'd1,
        IMM = 2'd2,
        PC  = 2'd3
    } wr_src_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage -> writeback handshake, load response and register-file write port.
// Optional WB_RETIRE_CNT_EN adds the retired-instruction counter signal.
interface wb_stage_if #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
);
    localparam int RA_W  = $clog2(NUM_REGS);
    localparam int IDX_W = $clog2(XLEN/8);

    logic             wb_valid_i;
    logic             wb_ready_o;
    logic [RA_W-1:0]  rd_addr_i;
    logic             rd_wr_en_i;
    logic [1:0]       rf_wr_data_src_i;
    logic [XLEN-1:0]  alu_res_i;
    logic [XLEN-1:0]  instr_imm_i;
    logic [XLEN-1:0]  pc_val_i;
    logic [1:0]       data_byte_en_i;
    logic             data_zero_extnd_i;
    logic [IDX_W-1:0] data_mem_row_idx_i;
    logic             mem_rsp_valid_i;
    logic [XLEN-1:0]  mem_rsp_data_i;
    logic             rf_wr_en_o;
    logic [RA_W-1:0]  rf_wr_addr_o;
    logic [XLEN-1:0]  rf_wr_data_o;
    logic             rsp_unexp_o;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]      retire_cnt_o;
`endif

    modport master (
        output wb_valid_i, rd_addr_i, rd_wr_en_i, rf_wr_data_src_i, alu_res_i,
               instr_imm_i, pc_val_i, data_byte_en_i, data_zero_extnd_i,
               data_mem_row_idx_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  wb_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rsp_unexp_o
`ifdef WB_RETIRE_CNT_EN
        , input retire_cnt_o
`endif
    );

    modport slave (
        input  wb_valid_i, rd_addr_i, rd_wr_en_i, rf_wr_data_src_i, alu_res_i,
               instr_imm_i, pc_val_i, data_byte_en_i, data_zero_extnd_i,
               data_mem_row_idx_i, mem_rsp_valid_i, mem_rsp_data_i,
        output wb_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rsp_unexp_o
`ifdef WB_RETIRE_CNT_EN
        , output retire_cnt_o
`endif
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load data alignment: shift the memory row down to the addressed byte, truncate, extend.
module wb_load_align
    import cpu_consts::*;
#(
    parameter int XLEN  = 64,
    parameter int IDX_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  row,
    input  logic [IDX_W-1:0] idx,
    input  byte_en_t         size,
    input  logic             zext,
    output logic [XLEN-1:0]  data
);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] word_ext;

    assign shifted  = row >> {idx, 3'b000};
    assign word_ext = zext ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));

    always_comb begin
        data = word_ext;
        case (size)
            BYTE:      data = zext ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            HALF_WORD: data = zext ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            WORD:      data = word_ext;
            // a 32-bit datapath has no doubleword, so it falls back to a word load
            DOUBLE:    data = (XLEN == 32) ? word_ext : shifted;
            default:   data = word_ext;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered, handshaked writeback stage with a variable-latency load wait state.
// Define WB_RETIRE_CNT_EN to add the 64-bit retired-instruction counter.
module wb_stage
    import cpu_consts::*;
#(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic     clk,
    input  logic     resetn,
    wb_stage_if.slave bus
);
    localparam int RA_W  = $clog2(NUM_REGS);
    localparam int IDX_W = $clog2(XLEN/8);

    wb_state_t        state_q, state_d;
    logic [RA_W-1:0]  pend_rd_q;
    logic             pend_we_q;
    byte_en_t         pend_sz_q;
    logic             pend_zx_q;
    logic [IDX_W-1:0] pend_idx_q;

    logic             ready, acc, is_mem;
    logic             complete, capture, take_rsp, sel_pend, unexp_d;
    logic [RA_W-1:0]  wr_rd;
    logic             wr_we;
    logic [XLEN-1:0]  src_data, load_data, wr_data;
    logic [IDX_W-1:0] al_idx;
    byte_en_t         al_sz;
    logic             al_zx;

    assign ready  = resetn && (state_q == IDLE);
    assign acc    = bus.wb_valid_i && ready;
    assign is_mem = wr_src_t'(bus.rf_wr_data_src_i) == MEM;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        capture  = 1'b0;
        take_rsp = 1'b0;
        sel_pend = 1'b0;
        unexp_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && !is_mem) begin
                    complete = 1'b1;
                end else if (acc && bus.mem_rsp_valid_i) begin
                    complete = 1'b1;
                    take_rsp = 1'b1;
                end else if (acc) begin
                    capture = 1'b1;
                    state_d = WAIT_MEM;
                end
                // a response with no load to consume it is dropped and flagged
                if (bus.mem_rsp_valid_i && !(acc && is_mem)) unexp_d = 1'b1;
            end
            WAIT_MEM: begin
                if (bus.mem_rsp_valid_i) begin
                    complete = 1'b1;
                    take_rsp = 1'b1;
                    sel_pend = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign al_idx = sel_pend ? pend_idx_q : bus.data_mem_row_idx_i;
    assign al_sz  = sel_pend ? pend_sz_q  : byte_en_t'(bus.data_byte_en_i);
    assign al_zx  = sel_pend ? pend_zx_q  : bus.data_zero_extnd_i;
    assign wr_rd  = sel_pend ? pend_rd_q  : bus.rd_addr_i;
    assign wr_we  = sel_pend ? pend_we_q  : bus.rd_wr_en_i;

    wb_load_align #(.XLEN(XLEN), .IDX_W(IDX_W)) u_align (
        .row  (bus.mem_rsp_data_i),
        .idx  (al_idx),
        .size (al_sz),
        .zext (al_zx),
        .data (load_data)
    );

    always_comb begin
        src_data = '0;
        case (wr_src_t'(bus.rf_wr_data_src_i))
            ALU:     src_data = bus.alu_res_i;
            IMM:     src_data = bus.instr_imm_i;
            PC:      src_data = bus.pc_val_i;
            default: src_data = '0;
        endcase
    end

    assign wr_data = take_rsp ? load_data : src_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.rf_wr_en_o   <= 1'b0;
            bus.rf_wr_addr_o <= '0;
            bus.rf_wr_data_o <= '0;
            bus.rsp_unexp_o  <= 1'b0;
            pend_rd_q        <= '0;
            pend_we_q        <= 1'b0;
            pend_sz_q        <= BYTE;
            pend_zx_q        <= 1'b0;
            pend_idx_q       <= '0;
        end else begin
            bus.rf_wr_en_o  <= complete && wr_we && (wr_rd != '0);
            bus.rsp_unexp_o <= unexp_d;
            if (complete) begin
                bus.rf_wr_addr_o <= wr_rd;
                bus.rf_wr_data_o <= wr_data;
            end
            if (capture) begin
                pend_rd_q  <= bus.rd_addr_i;
                pend_we_q  <= bus.rd_wr_en_i;
                pend_sz_q  <= byte_en_t'(bus.data_byte_en_i);
                pend_zx_q  <= bus.data_zero_extnd_i;
                pend_idx_q <= bus.data_mem_row_idx_i;
            end
        end
    end

    assign bus.wb_ready_o = ready;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    // counts every completion, including x0 and non-writing instructions
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       retire_cnt_q <= '0;
        else if (complete) retire_cnt_q <= retire_cnt_q + 64'd1;
    end

    assign bus.retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Writeback stage bench: directed scenarios then random traffic against a transaction-level model.
module tb_wb_stage;
    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus ();

    wb_stage #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // model: a single outstanding load plus the expected outputs after the next edge
    bit          m_pend;
    logic [4:0]  m_rd;
    bit          m_we;
    int          m_sz, m_idx;
    bit          m_zx;
    logic [63:0] m_cnt;
    bit          e_en, e_unexp;
    logic [4:0]  e_addr;
    logic [63:0] e_data;

    function automatic logic [63:0] ref_load(input logic [63:0] row, input int idx,
                                              input int sz, input bit zx);
        int          bits;
        logic [63:0] v, mask;
        bits = (sz == 0) ? 8 : (sz == 1) ? 16 : (sz == 2) ? 32 : 64;
        v    = row >> (8 * idx);
        mask = (bits == 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
        v    = v & mask;
        if (!zx && bits < 64 && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic predict();
        bit rsp, acc, mem, was_pend, done;
        rsp      = bus.mem_rsp_valid_i;
        was_pend = m_pend;
        acc      = bus.wb_valid_i && !m_pend;
        mem      = (bus.rf_wr_data_src_i == 2'd1);
        done     = 0;
        e_en     = 0;
        e_unexp  = 0;
        if (was_pend) begin
            if (rsp) begin
                done   = 1;
                e_en   = m_we && (m_rd != 0);
                e_addr = m_rd;
                e_data = ref_load(bus.mem_rsp_data_i, m_idx, m_sz, m_zx);
                m_pend = 0;
            end
        end else if (acc) begin
            e_addr = bus.rd_addr_i;
            if (!mem || rsp) begin
                done = 1;
                e_en = bus.rd_wr_en_i && (bus.rd_addr_i != 0);
                case (bus.rf_wr_data_src_i)
                    2'd0: e_data = bus.alu_res_i;
                    2'd2: e_data = bus.instr_imm_i;
                    2'd3: e_data = bus.pc_val_i;
                    default: e_data = ref_load(bus.mem_rsp_data_i, int'(bus.data_mem_row_idx_i),
                                               int'(bus.data_byte_en_i), bus.data_zero_extnd_i);
                endcase
            end else begin
                m_pend = 1;
                m_rd   = bus.rd_addr_i;
                m_we   = bus.rd_wr_en_i;
                m_sz   = int'(bus.data_byte_en_i);
                m_zx   = bus.data_zero_extnd_i;
                m_idx  = int'(bus.data_mem_row_idx_i);
            end
        end
        if (!was_pend && rsp && !(acc && mem)) e_unexp = 1;
        if (done) m_cnt = m_cnt + 64'd1;
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        chk("wr_en", 64'(bus.rf_wr_en_o), 64'(e_en));
        if (e_en) begin
            chk("wr_addr", 64'(bus.rf_wr_addr_o), 64'(e_addr));
            chk("wr_data", bus.rf_wr_data_o, e_data);
        end
        chk("unexp", 64'(bus.rsp_unexp_o), 64'(e_unexp));
        chk("ready", 64'(bus.wb_ready_o), 64'(!m_pend));
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", bus.retire_cnt_o, m_cnt);
`endif
    endtask

    task automatic set_instr(input bit v, input int rd, input bit we, input int src,
                             input logic [63:0] val, input int sz, input bit zx, input int idx);
        bus.wb_valid_i         = v;
        bus.rd_addr_i          = 5'(rd);
        bus.rd_wr_en_i         = we;
        bus.rf_wr_data_src_i   = 2'(src);
        bus.alu_res_i          = val;
        bus.instr_imm_i        = ~val;
        bus.pc_val_i           = val ^ 64'h00F0_00F0_00F0_00F0;
        bus.data_byte_en_i     = 2'(sz);
        bus.data_zero_extnd_i  = zx;
        bus.data_mem_row_idx_i = 3'(idx);
    endtask

    task automatic set_rsp(input bit v, input logic [63:0] row);
        bus.mem_rsp_valid_i = v;
        bus.mem_rsp_data_i  = row;
    endtask

    task automatic rand_inputs();
        set_instr(($urandom % 4) != 0, int'($urandom % 32), ($urandom % 8) != 0,
                  int'($urandom % 4), {$urandom, $urandom}, int'($urandom % 4),
                  bit'($urandom % 2), int'($urandom % 8));
        set_rsp(m_pend ? (($urandom % 3) == 0) : (($urandom % 5) == 0), {$urandom, $urandom});
    endtask

    logic [63:0] cnt0;

    initial begin
        m_pend = 0;
        m_cnt  = '0;
        set_instr(0, 0, 0, 0, '0, 0, 0, 0);
        set_rsp(0, '0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", 64'(bus.rf_wr_en_o), 64'd0);
        chk("rst_addr", 64'(bus.rf_wr_addr_o), 64'd0);
        chk("rst_data", bus.rf_wr_data_o, 64'd0);
        chk("rst_unexp", 64'(bus.rsp_unexp_o), 64'd0);
        chk("rst_ready", 64'(bus.wb_ready_o), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_cnt", bus.retire_cnt_o, 64'd0);
`endif
        resetn = 1'b1;
        #1;
        chk("rel_ready", 64'(bus.wb_ready_o), 64'd1);

        // 1: ALU write rd=5
        set_instr(1, 5, 1, 0, 64'h1234, 0, 0, 0);
        step();
        chk("t1_data", bus.rf_wr_data_o, 64'h1234);
        chk("t1_addr", 64'(bus.rf_wr_addr_o), 64'd5);
        set_instr(0, 0, 0, 0, '0, 0, 0, 0);
        step();
        chk("t1_pulse", 64'(bus.rf_wr_en_o), 64'd0);

        // 2: LB sign-extend, idx 3, response three cycles late
        set_instr(1, 7, 1, 1, '0, 0, 0, 3);
        step();
        set_instr(0, 0, 0, 0, '0, 0, 0, 0);
        step();
        step();
        chk("t2_ready3", 64'(bus.wb_ready_o), 64'd0);
        set_rsp(1, 64'h0000_0000_8000_0000);
        step();
        set_rsp(0, '0);
        chk("t2_data", bus.rf_wr_data_o, 64'hFFFF_FFFF_FFFF_FF80);

        // 3: LHU zero-extend, idx 6, zero-wait
        set_instr(1, 9, 1, 1, '0, 1, 1, 6);
        set_rsp(1, 64'hBEEF_0000_0000_0000);
        step();
        set_rsp(0, '0);
        chk("t3_data", bus.rf_wr_data_o, 64'h0000_0000_0000_BEEF);

        // 4: back-to-back rd=0 then rd=1
        cnt0 = m_cnt;
        set_instr(1, 0, 1, 0, 64'hAAAA, 0, 0, 0);
        step();
        chk("t4_x0", 64'(bus.rf_wr_en_o), 64'd0);
        set_instr(1, 1, 1, 2, 64'h5555, 0, 0, 0);
        step();
        chk("t4_rd1", 64'(bus.rf_wr_en_o), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        chk("t4_cnt", bus.retire_cnt_o - cnt0, 64'd2);
`endif

        // 5: unexpected response in IDLE
        set_instr(0, 0, 0, 0, '0, 0, 0, 0);
        set_rsp(1, 64'h1111);
        step();
        chk("t5_unexp", 64'(bus.rsp_unexp_o), 64'd1);
        set_rsp(0, '0);
        step();
        chk("t5_pulse", 64'(bus.rsp_unexp_o), 64'd0);

        // 6: reset while waiting on a load, then a late response
        set_instr(1, 12, 1, 1, '0, 2, 0, 0);
        step();
        set_instr(0, 0, 0, 0, '0, 0, 0, 0);
        step();
        resetn = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(bus.wb_ready_o), 64'd0);
        m_pend = 0;
        m_cnt  = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        set_rsp(1, 64'h2222);
        step();
        chk("t6_unexp", 64'(bus.rsp_unexp_o), 64'd1);
        chk("t6_noen", 64'(bus.rf_wr_en_o), 64'd0);
        set_rsp(0, '0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
